clk_meter: RTL
==============

CLK_METER -- requirements
Module: clk_meter

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 1023, the maximum clk cycles allowed while waiting for any clk_in edge.
REQ-002 SHALL provide port clk  input  1  system clock; the only clock in the block.
REQ-003 SHALL provide port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port clk_in  input  1  measured clock (e.g. dcm clk_1/clk_2); asynchronous to clk.
REQ-005 SHALL provide port start  input  1  single-cycle request to begin one measurement.
REQ-006 SHALL provide port busy  output  1  high while a measurement is in progress.
REQ-007 SHALL provide port valid  output  1  one-cycle pulse when a measurement finishes, good or bad.
REQ-008 SHALL provide port period  output  10  clk cycles between two consecutive clk_in rising edges.
REQ-009 SHALL provide port prog_det  output  3  decoded divider setting.
REQ-010 SHALL provide port err  output  1  last measurement was a timeout or an illegal period.

Function
REQ-011 SHALL pass clk_in through a 2-flop synchronizer plus one history flop, and generate a one-cycle rise pulse when the synchronized value goes 0->1.
REQ-012 SHALL implement FSM states IDLE, ARM, COUNT and DONE.
REQ-013 SHALL move IDLE->ARM on start=1; start SHALL be ignored in any other state.
REQ-014 SHALL, in ARM, clear the cycle counter and move to COUNT on the first rise pulse.
REQ-015 SHALL, in COUNT, increment the counter every cycle and move to DONE on the next rise pulse.
REQ-016 SHALL set period = number of clk cycles between the two rise pulses, so a clk_in of exactly P clk cycles yields period=P.
REQ-017 SHALL decode the period as follows: if period = 2^(k+1) for k in 0..7 (2,4,...,256), then prog_det=k and err=0.
REQ-018 SHALL treat any other period (non-power-of-two, 1, or >256) as illegal: err=1, prog_det=0, and period still reports the measured count.
REQ-019 SHALL, in ARM or COUNT, when the counter reaches TIMEOUT with no rise pulse, go to DONE with err=1, period=TIMEOUT and prog_det=0.
REQ-020 SHALL, in DONE, pulse valid for exactly one cycle, then return to IDLE.
REQ-021 SHALL hold period, prog_det and err stable from DONE until the next DONE.
REQ-022 SHALL assert busy in ARM, COUNT and DONE, and deassert it in IDLE.
REQ-023 SHALL hold the counter at TIMEOUT and never let it wrap.
REQ-024 SHALL honour a start arriving in the same cycle that valid is high only if the FSM is in IDLE on that cycle; otherwise the start is dropped.
REQ-025 SHALL measure a clk_in that changes frequency mid-measurement over whichever two edges actually occur; the block SHALL NOT retry.

Reset
REQ-026 SHALL, while rst=0, immediately force state=IDLE, counter=0, synchronizer flops=0, busy=0, valid=0, period=0, prog_det=0 and err=0.
REQ-027 SHALL, when rst is asserted mid-measurement, abort the measurement with no valid pulse.
REQ-028 SHALL, after rst is released, require a new start before measuring.
REQ-029 SHALL treat the first sample after reset as a 0 history value, so a clk_in that is already high at reset release produces a rise pulse.

Verification
REQ-030 SHALL verify: clk_in = clk/4, start -> valid within 12 cycles, period=4, prog_det=1, err=0.
REQ-031 SHALL verify: clk_in = clk/256 -> period=256, prog_det=7, err=0; then clk_in = clk/8 with a new start -> period=8, prog_det=2.
REQ-032 SHALL verify: clk_in held at 0, start -> valid after TIMEOUT cycles with err=1, period=1023, prog_det=0.
REQ-033 SHALL verify: clk_in period of 6 clk cycles -> period=6, err=1, prog_det=0.
REQ-034 SHALL verify: start pulsed again while busy=1 -> exactly one valid pulse and unchanged results.
REQ-035 SHALL verify: rst=0 during COUNT -> all outputs 0 with no valid pulse; a new start after release gives a correct measurement.

Source files
------------

// File: rtl/clk_meter.sv
`default_nettype none
// ============================================================================
// Module   : clk_meter
// Brief    : Measures one clk_in period in clk cycles and decodes the divider.
// Revision : 1.0 - initial release
// ============================================================================
module clk_meter #(
    parameter int TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_in,
    input  logic       start,
    output logic       busy,
    output logic       valid,
    output logic [9:0] period,
    output logic [2:0] prog_det,
    output logic       err
);

    localparam int            CW        = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] C_TIMEOUT = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_COUNT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [9:0]    period_q, period_d;
    logic [2:0]    prog_q, prog_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic          valid_q, valid_d;
    logic          sync1_q, sync2_q, hist_q;
    logic          w_rise;
    logic          w_dec_ok;
    logic [2:0]    w_dec_k;

    assign w_rise = sync2_q & ~hist_q;

    // Legal periods are exactly 2^(k+1), k = 0..7
    always_comb begin
        w_dec_ok = 1'b0;
        w_dec_k  = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (32'(cnt_q) == (32'd2 << k)) begin
                w_dec_ok = 1'b1;
                w_dec_k  = 3'(k);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        prog_d   = prog_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ARM;
                    cnt_d   = '0;
                end
            end
            S_ARM: begin
                if (w_rise) begin
                    state_d = S_COUNT;
                    cnt_d   = CW'(1);
                end else if (cnt_q == C_TIMEOUT) begin
                    state_d  = S_DONE;
                    period_d = 10'(TIMEOUT);
                    prog_d   = 3'd0;
                    err_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_COUNT: begin
                // cnt_q already equals the cycles elapsed since the first rise
                if (w_rise) begin
                    state_d  = S_DONE;
                    period_d = 10'(cnt_q);
                    prog_d   = w_dec_ok ? w_dec_k : 3'd0;
                    err_d    = ~w_dec_ok;
                end else if (cnt_q == C_TIMEOUT) begin
                    state_d  = S_DONE;
                    period_d = 10'(TIMEOUT);
                    prog_d   = 3'd0;
                    err_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d  = (state_d != S_IDLE);
        valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            prog_q   <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            hist_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            prog_q   <= prog_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            sync1_q  <= clk_in;
            sync2_q  <= sync1_q;
            hist_q   <= sync2_q;
        end
    end

    assign busy     = busy_q;
    assign valid    = valid_q;
    assign period   = period_q;
    assign prog_det = prog_q;
    assign err      = err_q;

endmodule
`default_nettype wire
